// File: rtl/vc_scfifo.sv
// vc_scfifo -- single-clock FIFO holding NUM_VC independent queues in one
// partitioned storage array (VC v owns words v*DEPTH .. v*DEPTH+DEPTH-1).
//
// Ports:
//   clock        sole clock, rising edge
//   aclr_n       asynchronous active-low reset
//   data/wrreq/wrvc   write port: word, request, target VC
//   rdreq/rdvc        read port: pop request, source VC
//   q            read data (registered when SHOWAHEAD="OFF", lookahead when "ON")
//   empty/full/almost_full  per-VC flags, decoded from registered occupancy
//   usedw        per-VC occupancy, VC v at [v*(AW+1) +: AW+1]
//   overflow     sticky: a write was dropped (full VC or VC out of range)
//   underflow    sticky: a read was dropped (empty VC or VC out of range)

// Per-VC pointer/occupancy state. Pointers are AW+1 bits so they wrap
// modulo 2*DEPTH; only the low AW bits leave the module as addresses.
module vc_scfifo_ptr #(
   parameter int AW = 3
) (
   input  logic          clock,
   input  logic          aclr_n,
   input  logic          wr_acc,
   input  logic          rd_acc,
   output logic [AW-1:0] wr_addr,
   output logic [AW-1:0] rd_addr,
   output logic [AW:0]   cnt
);
   logic [AW:0] wr_ptr, rd_ptr;

   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_acc, rd_acc})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   assign wr_addr = wr_ptr[AW-1:0];
   assign rd_addr = rd_ptr[AW-1:0];
endmodule

module vc_scfifo #(
   parameter int    WIDTH       = 512,
   parameter int    DEPTH       = 8,
   parameter int    NUM_VC      = 2,
   parameter int    ALMOST_FULL = DEPTH - 1,
   parameter string SHOWAHEAD   = "OFF",
   localparam int   AW          = $clog2(DEPTH),
   localparam int   VW          = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
   input  logic                     clock,
   input  logic                     aclr_n,
   input  logic [WIDTH-1:0]         data,
   input  logic                     wrreq,
   input  logic [VW-1:0]            wrvc,
   input  logic                     rdreq,
   input  logic [VW-1:0]            rdvc,
   output logic [WIDTH-1:0]         q,
   output logic [NUM_VC-1:0]        empty,
   output logic [NUM_VC-1:0]        full,
   output logic [NUM_VC-1:0]        almost_full,
   output logic [NUM_VC*(AW+1)-1:0] usedw,
   output logic                     overflow,
   output logic                     underflow
);
   localparam int MW = (NUM_VC * DEPTH > 1) ? $clog2(NUM_VC * DEPTH) : 1;

   logic [NUM_VC-1:0][AW:0]   cnt;
   logic [NUM_VC-1:0][AW-1:0] wr_addr, rd_addr;
   logic [NUM_VC-1:0]         wr_hit, rd_hit, rd_sel;
   logic [MW-1:0]             waddr, raddr;
   logic [WIDTH-1:0]          mem [NUM_VC*DEPTH];

   // Acceptance is decoded per VC against registered flags only. An
   // out-of-range VC matches no lane, so it falls out as a rejection.
   genvar v;
   generate
      for (v = 0; v < NUM_VC; v++) begin : g_vc
         assign empty[v]       = (cnt[v] == '0);
         assign full[v]        = (cnt[v] == (AW+1)'(DEPTH));
         assign almost_full[v] = (cnt[v] >= (AW+1)'(ALMOST_FULL));
         assign rd_sel[v]      = (rdvc == VW'(v));
         assign wr_hit[v]      = wrreq && (wrvc == VW'(v)) && !full[v];
         assign rd_hit[v]      = rdreq && rd_sel[v] && !empty[v];

         vc_scfifo_ptr #(.AW(AW)) u_ptr (
            .clock   (clock),
            .aclr_n  (aclr_n),
            .wr_acc  (wr_hit[v]),
            .rd_acc  (rd_hit[v]),
            .wr_addr (wr_addr[v]),
            .rd_addr (rd_addr[v]),
            .cnt     (cnt[v])
         );
      end
   endgenerate

   assign usedw = cnt;

   // At most one lane can hit per port, so an OR-style mux is enough.
   always_comb begin
      waddr = '0;
      raddr = '0;
      for (int i = 0; i < NUM_VC; i++) begin
         if (wr_hit[i]) waddr = MW'(i * DEPTH) + MW'(wr_addr[i]);
         if (rd_sel[i]) raddr = MW'(i * DEPTH) + MW'(rd_addr[i]);
      end
   end

   // Storage is intentionally not reset.
   always_ff @(posedge clock) begin
      if (|wr_hit) mem[waddr] <= data;
   end

   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wrreq && !(|wr_hit)) overflow  <= 1'b1;
         if (rdreq && !(|rd_hit)) underflow <= 1'b1;
      end
   end

   generate
      if (SHOWAHEAD == "ON") begin : g_show
         // Lookahead: head of rdvc straight from storage, forced to 0 when
         // that VC is empty (or rdvc is out of range).
         assign q = (|(rd_sel & ~empty)) ? mem[raddr] : '0;
      end else begin : g_reg
         always_ff @(posedge clock or negedge aclr_n) begin
            if (!aclr_n)      q <= '0;
            else if (|rd_hit) q <= mem[raddr];
         end
      end
   endgenerate
endmodule
